// File: rtl/nbout_psum_buffer.sv
// nbout_psum_buffer
//
// Output neuron buffer (NBout) controller around the NFU-1/NFU-2 datapath.
// Each cycle it issues one Tn-lane partial-sum entry to NFU-2 and captures the
// matching NFU-2 result LAT cycles later. The result is written back to the
// same entry, so sums (or running maxima) accumulate over several passes.
// After the last pass the finished entries are drained over valid/ready.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   i_start         one-cycle job start pulse (honoured only in IDLE)
//   i_num_entries   entries per pass, 1..DEPTH (others ignore the start)
//   i_num_passes    passes per job, 0 treated as 1
//   i_op            0 = sum (init 0), 1 = max (init most-negative per lane)
//   o_issue/o_psum  partial-sum entry to NFU-2 (o_psum is 0 when not issuing)
//   i_result        NFU-2 output, valid LAT cycles after the matching o_issue
//   o_out_valid/o_out_data/i_out_ready  drain handshake
//   o_busy          high in every state except IDLE
//   o_done          one-cycle pulse when the job completes
//
// Optional feature (compile-time macro NBOUT_DRAIN_RELU_EN):
//   defined   -> each drained lane is clamped to 0 when negative
//   undefined -> drained values pass through unmodified

module nbout_psum_buffer #(
  parameter int N      = 16,
  parameter int Tn     = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int LAT    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_num_entries,
  input  logic [15:0]       i_num_passes,
  input  logic              i_op,
  output logic              o_issue,
  output logic [N*Tn-1:0]   o_psum,
  input  logic [N*Tn-1:0]   i_result,
  output logic              o_out_valid,
  output logic [N*Tn-1:0]   o_out_data,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Job configuration
  logic [ADDR_W:0]   ne_q, ne_d;
  logic [15:0]       np_q, np_d;
  logic              op_q, op_d;

  // Next entry to issue (candidate) and the entry issued this cycle
  logic [ADDR_W-1:0] cand_addr_q, cand_addr_d;
  logic [15:0]       cand_pass_q, cand_pass_d;
  logic [ADDR_W-1:0] iss_addr_q, iss_addr_d;

  // Registered outputs
  logic              issue_q, issue_d;
  logic [N*Tn-1:0]   psum_q, psum_d;
  logic              out_valid_q, out_valid_d;
  logic [N*Tn-1:0]   out_data_q, out_data_d;
  logic              busy_q;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;

  // In-flight tracker: slot k holds the issue made k cycles ago
  logic [LAT:1]      trk_vld_q;
  logic [ADDR_W-1:0] trk_addr_q [1:LAT];

  logic [N*Tn-1:0]   mem [0:DEPTH-1];

  logic [ADDR_W-1:0] rd_addr;
  logic [N*Tn-1:0]   rd_data;
  logic              hazard;
  logic              trk_busy;
  logic              start_ok;
  logic              do_issue;

  assign o_issue     = issue_q;
  assign o_psum      = psum_q;
  assign o_out_valid = out_valid_q;
  assign o_out_data  = out_data_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

  function automatic logic [N*Tn-1:0] init_val(input logic op);
    logic [N*Tn-1:0] v;
    for (int l = 0; l < Tn; l++) begin
      v[l*N +: N] = op ? {1'b1, {(N-1){1'b0}}} : '0;
    end
    return v;
  endfunction

  function automatic logic [N*Tn-1:0] drain_fmt(input logic [N*Tn-1:0] d);
    logic [N*Tn-1:0]  v;
    logic signed [N-1:0] lane;
    for (int l = 0; l < Tn; l++) begin
      lane = d[l*N +: N];
`ifdef NBOUT_DRAIN_RELU_EN
      if (lane < 0) lane = '0;
`endif
      v[l*N +: N] = lane;
    end
    return v;
  endfunction

  assign start_ok = (i_num_entries != '0) &&
                    (i_num_entries <= (ADDR_W+1)'(DEPTH));

  // Issue decisions are made one cycle ahead because o_issue is registered.
  // The cycle being decided sees the tracker shifted by one: the current
  // issue moves into slot 1 and slot LAT retires (its write lands at this
  // edge and is forwarded below), so only slots 1..LAT-1 can conflict.
  always_comb begin
    hazard   = issue_q && (iss_addr_q == cand_addr_q);
    trk_busy = issue_q;
    for (int k = 1; k < LAT; k++) begin
      if (trk_vld_q[k]) begin
        trk_busy = 1'b1;
        if (trk_addr_q[k] == cand_addr_q) hazard = 1'b1;
      end
    end
  end

  always_comb begin
    case (state_q)
      FLUSH:   rd_addr = '0;
      DRAIN:   rd_addr = drain_addr_q + ADDR_W'(1);
      default: rd_addr = cand_addr_q;
    endcase
  end

  // Forward the result being written this cycle so a read never sees stale data
  assign rd_data = (trk_vld_q[LAT] && (trk_addr_q[LAT] == rd_addr)) ?
                   i_result : mem[rd_addr];

  always_comb begin
    state_d      = state_q;
    ne_d         = ne_q;
    np_d         = np_q;
    op_d         = op_q;
    cand_addr_d  = cand_addr_q;
    cand_pass_d  = cand_pass_q;
    iss_addr_d   = iss_addr_q;
    issue_d      = 1'b0;
    psum_d       = '0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    drain_addr_d = drain_addr_q;
    done_d       = 1'b0;
    do_issue     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start && start_ok) begin
          ne_d        = i_num_entries;
          np_d        = (i_num_passes == 16'd0) ? 16'd1 : i_num_passes;
          op_d        = i_op;
          cand_addr_d = '0;
          cand_pass_d = '0;
          state_d     = ISSUE;
          do_issue    = 1'b1;
        end
      end
      ISSUE: begin
        do_issue = !hazard;
      end
      FLUSH: begin
        if (!trk_busy) begin
          state_d      = DRAIN;
          drain_addr_d = '0;
          out_valid_d  = 1'b1;
          out_data_d   = drain_fmt(rd_data);
        end
      end
      DRAIN: begin
        if (out_valid_q && i_out_ready) begin
          if ({1'b0, drain_addr_q} == ne_q - (ADDR_W+1)'(1)) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            done_d      = 1'b1;
          end else begin
            drain_addr_d = drain_addr_q + ADDR_W'(1);
            out_data_d   = drain_fmt(rd_data);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_issue) begin
      issue_d    = 1'b1;
      iss_addr_d = cand_addr_d;
      psum_d     = (cand_pass_d == 16'd0) ? init_val(op_d) : rd_data;
      if ({1'b0, cand_addr_d} == ne_d - (ADDR_W+1)'(1)) begin
        if (cand_pass_d == np_d - 16'd1) state_d = FLUSH;
        cand_addr_d = '0;
        cand_pass_d = cand_pass_d + 16'd1;
      end else begin
        cand_addr_d = cand_addr_d + ADDR_W'(1);
      end
    end
  end

  // Control state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_q     <= 1'b0;
      psum_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trk_vld_q   <= '0;
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      psum_q      <= psum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= done_d;
      trk_vld_q   <= {trk_vld_q[LAT-1:1], issue_q};
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    ne_q          <= ne_d;
    np_q          <= np_d;
    op_q          <= op_d;
    cand_addr_q   <= cand_addr_d;
    cand_pass_q   <= cand_pass_d;
    iss_addr_q    <= iss_addr_d;
    drain_addr_q  <= drain_addr_d;
    trk_addr_q[1] <= iss_addr_q;
    for (int k = 2; k <= LAT; k++) begin
      trk_addr_q[k] <= trk_addr_q[k-1];
    end
  end

  // Result write-back; results arriving during reset are dropped
  always_ff @(posedge clk) begin
    if (!rst && trk_vld_q[LAT]) begin
      mem[trk_addr_q[LAT]] <= i_result;
    end
  end

endmodule

// File: tb/tb_nbout_psum_buffer.sv
module tb_nbout_psum_buffer;

  localparam int LAT = 6;
  localparam int W   = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [6:0]    i_num_entries = '0;
  logic [15:0]   i_num_passes = '0;
  logic          i_op = 1'b0;
  logic          o_issue;
  logic [W-1:0]  o_psum;
  logic [W-1:0]  i_result;
  logic          o_out_valid;
  logic [W-1:0]  o_out_data;
  logic          i_out_ready = 1'b0;
  logic          o_busy;
  logic          o_done;

  nbout_psum_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_num_entries (i_num_entries),
    .i_num_passes  (i_num_passes),
    .i_op          (i_op),
    .o_issue       (o_issue),
    .o_psum        (o_psum),
    .i_result      (i_result),
    .o_out_valid   (o_out_valid),
    .o_out_data    (o_out_data),
    .i_out_ready   (i_out_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // NFU stand-in: returns a function of o_psum exactly LAT cycles later
  int           res_mode = 0;
  int           ne_tb = 1;
  int           base = 0;
  int           iss_cyc[$];
  logic [W-1:0] iss_psum[$];
  logic [W-1:0] hist [0:LAT];

  function automatic logic [W-1:0] resp(input logic [W-1:0] p, input int idx);
    logic [W-1:0] r;
    for (int l = 0; l < 16; l++) begin
      case (res_mode)
        0:       r[l*16 +: 16] = p[l*16 +: 16] + 16'd1;
        1:       r[l*16 +: 16] = 16'd7;
        2:       r[l*16 +: 16] = 16'hFFFB;
        default: r[l*16 +: 16] = p[l*16 +: 16] + 16'(idx + 1);
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = resp(o_psum, (iss_cyc.size() - base) % ne_tb);
    i_result = hist[LAT];
    if (o_issue) begin
      iss_cyc.push_back(cyc);
      iss_psum.push_back(o_psum);
    end
  end

  initial begin
    for (int k = 0; k <= LAT; k++) hist[k] = '0;
    i_result = '0;
  end

  logic [W-1:0] drained[$];
  int           done_cnt;

  // Called at a negedge: starts a job and checks the first issue follows at once
  task automatic run_job(input int ne, input int np, input logic op, input int mode);
    base          = iss_cyc.size();
    res_mode      = mode;
    ne_tb         = ne;
    i_num_entries = 7'(ne);
    i_num_passes  = 16'(np);
    i_op          = op;
    i_start       = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("first_issue_busy", {o_busy, o_issue}, 2'b11);
  endtask

  task automatic drain(input int stall_after, input int stall_len, input int budget,
                       output int stall_ok);
    int acc = 0;
    int stall_left = 0;
    bit stalled = 0;
    bit got_done = 0;
    logic [W-1:0] held = '0;
    stall_ok = 0;
    done_cnt = 0;
    drained.delete();
    for (int c = 0; c < budget && !got_done; c++) begin
      @(negedge clk);
      if (o_done) begin
        done_cnt++;
        got_done = 1;
      end
      if (!stalled && stall_after >= 0 && acc == stall_after && o_out_valid) begin
        stalled    = 1;
        stall_left = stall_len;
        held       = o_out_data;
      end
      if (stall_left > 0) begin
        i_out_ready = 1'b0;
        if (o_out_valid && o_out_data == held) stall_ok++;
        stall_left--;
      end else begin
        i_out_ready = 1'b1;
        if (o_out_valid) begin
          drained.push_back(o_out_data);
          acc++;
        end
      end
    end
    if (!got_done) chk("drain_timeout", 1'b0, 1'b1);
    i_out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (o_done) done_cnt++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    int sok;
    logic [15:0] relu_exp;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {o_issue, o_out_valid, o_busy, o_done}, 4'b0);
    chk("reset_psum", o_psum, '0);
    chk("reset_out_data", o_out_data, '0);

    // Hazard stall: 4 entries, 3 passes, +1 per pass
    run_job(4, 3, 1'b0, 0);
    drain(-1, 0, 400, sok);
    n = iss_cyc.size() - base;
    chk("t1_issue_count", n, 12);
    if (n == 12) begin
      bad = 0;
      for (int k = 1; k < 4; k++) if (iss_cyc[base+k] - iss_cyc[base+k-1] != 1) bad++;
      for (int k = 4; k < 12; k++) if (iss_cyc[base+k] - iss_cyc[base+k-4] != 7) bad++;
      chk("t1_issue_gaps", bad, 0);
      chk("t1_reissue_e0", iss_cyc[base+4] - iss_cyc[base], 7);
      bad = 0;
      for (int k = 0; k < 12; k++) if (iss_psum[base+k] != {16{16'(k/4)}}) bad++;
      chk("t1_psum_values", bad, 0);
    end
    chk("t1_drain_count", drained.size(), 4);
    bad = 0;
    foreach (drained[i]) if (drained[i] != {16{16'd3}}) bad++;
    chk("t1_drain_values", bad, 0);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_idle_after", o_busy, 1'b0);

    // Max init: 2 entries, 1 pass, NFU returns 7
    run_job(2, 1, 1'b1, 1);
    drain(-1, 0, 200, sok);
    chk("t2_issue_count", iss_cyc.size() - base, 2);
    if (iss_cyc.size() - base == 2) begin
      chk("t2_psum_init0", iss_psum[base], {16{16'h8000}});
      chk("t2_psum_init1", iss_psum[base+1], {16{16'h8000}});
    end
    chk("t2_drain_count", drained.size(), 2);
    bad = 0;
    foreach (drained[i]) if (drained[i] != {16{16'd7}}) bad++;
    chk("t2_drain_values", bad, 0);

    // Full rate: 64 entries, 2 passes, stray start while busy
    run_job(64, 2, 1'b0, 0);
    repeat (20) @(negedge clk);
    i_num_entries = 7'd1;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    drain(-1, 0, 1000, sok);
    n = iss_cyc.size() - base;
    chk("t3_issue_count", n, 128);
    if (n == 128) begin
      chk("t3_back_to_back", iss_cyc[base+127] - iss_cyc[base], 127);
      chk("t3_pass1_psum", iss_psum[base+64], {16{16'd1}});
    end
    chk("t3_drain_count", drained.size(), 64);
    bad = 0;
    foreach (drained[i]) if (drained[i] != {16{16'd2}}) bad++;
    chk("t3_drain_values", bad, 0);
    chk("t3_done_pulses", done_cnt, 1);

    // Backpressure: entry i holds i+1, ready low 5 cycles after 3 accepts
    run_job(8, 1, 1'b0, 3);
    drain(3, 5, 400, sok);
    chk("t4_stall_hold", sok, 5);
    chk("t4_drain_count", drained.size(), 8);
    bad = 0;
    foreach (drained[i]) if (drained[i] != {16{16'(i + 1)}}) bad++;
    chk("t4_drain_order", bad, 0);

    // Reset mid-ISSUE, then a fresh job
    run_job(16, 4, 1'b0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_ctrl", {o_issue, o_out_valid, o_busy, o_done}, 4'b0);
    chk("t5_rst_psum", o_psum, '0);
    chk("t5_rst_out_data", o_out_data, '0);
    run_job(16, 2, 1'b0, 0);
    drain(-1, 0, 400, sok);
    n = iss_cyc.size() - base;
    chk("t5_issue_count", n, 32);
    if (n == 32) chk("t5_pass0_contig", iss_cyc[base+15] - iss_cyc[base], 15);
    chk("t5_drain_count", drained.size(), 16);
    bad = 0;
    foreach (drained[i]) if (drained[i] != {16{16'd2}}) bad++;
    chk("t5_drain_values", bad, 0);

    // Negative drained lanes
`ifdef NBOUT_DRAIN_RELU_EN
    relu_exp = 16'h0000;
`else
    relu_exp = 16'hFFFB;
`endif
    run_job(2, 1, 1'b0, 2);
    drain(-1, 0, 200, sok);
    chk("t6_drain_count", drained.size(), 2);
    bad = 0;
    foreach (drained[i]) if (drained[i] != {16{relu_exp}}) bad++;
    chk("t6_relu_values", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
